// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that connects one pixel-stream client at a time to the VGA adapter write port.
// Optional define PIXEL_CLIP_EN drops writes that fall outside the 160x120 framebuffer.
module pixel_write_arbiter #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned MAX_HOLD  = 19200,
  parameter int unsigned HOLD_W    = 15
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CLIENTS-1:0]   req,
  input  logic [N_CLIENTS-1:0]   done,
  input  logic [8*N_CLIENTS-1:0] x_in,
  input  logic [7*N_CLIENTS-1:0] y_in,
  input  logic [3*N_CLIENTS-1:0] colour_in,
  input  logic [N_CLIENTS-1:0]   write_in,
  output logic [N_CLIENTS-1:0]   grant,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             colour_out,
  output logic                   write_out,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e               r_state, w_state_d;
  logic [IDX_W-1:0]     r_last, r_gidx, w_sel;
  logic                 w_sel_vld;
  logic [HOLD_W-1:0]    r_hold;
  logic [N_CLIENTS-1:0] r_grant;
  logic [7:0]           r_x;
  logic [6:0]           r_y;
  logic [2:0]           r_colour;
  logic                 r_write, r_timeout, w_timeout;
  logic [7:0]           w_gx;
  logic [6:0]           w_gy;
  logic [2:0]           w_gcolour;
  logic                 w_gwrite, w_gdone, w_greq, w_hold_max, w_wr_fwd;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    return IDX_W'((32'(base) + off) % N_CLIENTS);
  endfunction

  // First requester strictly after the last grantee, wrapping.
  always_comb begin
    w_sel     = r_last;
    w_sel_vld = 1'b0;
    for (int unsigned off = 1; off <= N_CLIENTS; off++) begin
      if (!w_sel_vld && req[wrap_idx(r_last, off)]) begin
        w_sel     = wrap_idx(r_last, off);
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_gx       = x_in[8*32'(r_gidx) +: 8];
  assign w_gy       = y_in[7*32'(r_gidx) +: 7];
  assign w_gcolour  = colour_in[3*32'(r_gidx) +: 3];
  assign w_gwrite   = write_in[r_gidx];
  assign w_gdone    = done[r_gidx];
  assign w_greq     = req[r_gidx];
  assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD - 1));

`ifdef PIXEL_CLIP_EN
  assign w_wr_fwd = w_gwrite && (w_gx <= 8'd159) && (w_gy <= 7'd119);
`else
  assign w_wr_fwd = w_gwrite;
`endif

  always_comb begin
    w_state_d = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_sel_vld) w_state_d = StGrant;
      end
      StGrant: begin
        if (w_gdone || !w_greq) begin
          w_state_d = StRelease;
        end else if (w_hold_max) begin
          w_state_d = StRelease;
          w_timeout = 1'b1;
        end
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_last    <= IDX_W'(N_CLIENTS - 1);
      r_gidx    <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_write   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_timeout <= w_timeout;
      case (r_state)
        StIdle: begin
          r_write <= 1'b0;
          if (w_sel_vld) begin
            r_grant <= N_CLIENTS'(1) << w_sel;
            r_last  <= w_sel;
            r_gidx  <= w_sel;
            r_hold  <= '0;
          end
        end
        StGrant: begin
          // The exit-cycle pixel is still forwarded and shows during RELEASE.
          r_x      <= w_gx;
          r_y      <= w_gy;
          r_colour <= w_gcolour;
          r_write  <= w_wr_fwd;
          r_hold   <= r_hold + HOLD_W'(1);
          if (w_state_d == StRelease) r_grant <= '0;
        end
        StRelease: begin
          r_write <= 1'b0;
          r_hold  <= '0;
        end
        default: r_write <= 1'b0;
      endcase
    end
  end

  assign grant      = r_grant;
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_colour;
  assign write_out  = r_write;
  assign busy       = (r_state != StIdle);
  assign timeout    = r_timeout;

endmodule
